// File: rtl/multdiv_seq.sv
// multdiv_seq: sequential signed 32-bit multiplier / divider.
//
// A start pulse on ctrl_MULT or ctrl_DIV captures both operands and launches
// a new operation. Any earlier operation still in flight is abandoned. The
// result appears together with a one-cycle data_resultRDY strobe. Results
// and latched operands hold until they are overwritten or reset.
//
// Build option: define MULTDIV_DIV_EN to compile in the restoring divider.
// Without it, ctrl_DIV goes straight to DONE and reports an exception with a
// zero result.
//
// Ports:
//   clock          - rising-edge clock
//   reset          - synchronous, active-high reset
//   ctrl_MULT      - start signed multiply (one-cycle pulse, wins over ctrl_DIV)
//   ctrl_DIV       - start signed divide (one-cycle pulse)
//   data_operandA  - multiplicand / dividend
//   data_operandB  - multiplier / divisor
//   latched_A/B    - operands captured at the start edge
//   data_result    - low 32 bits of product, or quotient
//   data_exception - product overflow, divide-by-zero or divide overflow
//   data_resultRDY - one-cycle result-valid strobe
module multdiv_seq #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] latched_A,
  output logic [31:0] latched_B,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

`ifdef MULTDIV_DIV_EN
  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic [31:0]       result_q, result_d;
  logic              exc_q, exc_d;
  logic              rdy_q, rdy_d;

  // Multiplier: accumulator, left-shifting sign-extended multiplicand,
  // right-shifting multiplier.
  logic [63:0]       acc_q, acc_d;
  logic [63:0]       mcand_q, mcand_d;
  logic [31:0]       mplier_q, mplier_d;
  logic              mul_ovf;

  // Product bits [63:31] must all match for the low word to be exact.
  assign mul_ovf = ~((&acc_q[63:31]) | (~|acc_q[63:31]));

`ifdef MULTDIV_DIV_EN
  // Divider: remainder, dividend magnitude shifting into the quotient,
  // divisor magnitude, quotient sign.
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       dvsr_q, dvsr_d;
  logic              neg_q, neg_d;
  logic [31:0]       abs_a, abs_b;
  logic [32:0]       rem_shift, rem_diff;
  logic [31:0]       quo_signed;

  assign abs_a      = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign abs_b      = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;
  assign rem_shift  = {rem_q, quo_q[31]};
  assign rem_diff   = rem_shift - {1'b0, dvsr_q};
  assign quo_signed = neg_q ? (~quo_q + 32'd1) : quo_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef MULTDIV_DIV_EN
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_d    = neg_q;
`endif

    if (ctrl_MULT || ctrl_DIV) begin
      // A start is honoured in every state, aborting any operation in flight.
      a_d   = data_operandA;
      b_d   = data_operandB;
      cnt_d = '0;
      if (ctrl_MULT) begin
        state_d  = StMul;
        acc_d    = '0;
        mcand_d  = {{32{data_operandA[31]}}, data_operandA};
        mplier_d = data_operandB;
      end else begin
`ifdef MULTDIV_DIV_EN
        state_d = StDiv;
        rem_d   = '0;
        quo_d   = abs_a;
        dvsr_d  = abs_b;
        neg_d   = data_operandA[31] ^ data_operandB[31];
`else
        state_d  = StDone;
        result_d = '0;
        exc_d    = 1'b1;
        rdy_d    = 1'b1;
`endif
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StMul: begin
          if (cnt_q == CntW'(MUL_CYCLES)) begin
            state_d  = StDone;
            result_d = acc_q[31:0];
            exc_d    = mul_ovf;
            rdy_d    = 1'b1;
          end else begin
            // The multiplier's top bit carries weight -2^31, so subtract there.
            if (mplier_q[0]) begin
              if (cnt_q == CntW'(MUL_CYCLES - 1)) acc_d = acc_q - mcand_q;
              else                                acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[62:0], 1'b0};
            mplier_d = {1'b0, mplier_q[31:1]};
            cnt_d    = cnt_q + CntW'(1);
          end
        end
`ifdef MULTDIV_DIV_EN
        StDiv: begin
          if (cnt_q == CntW'(DIV_CYCLES)) begin
            state_d = StDone;
            rdy_d   = 1'b1;
            if (b_q == 32'd0) begin
              result_d = '0;
              exc_d    = 1'b1;
            end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
              result_d = 32'h8000_0000;
              exc_d    = 1'b1;
            end else begin
              result_d = quo_signed;
              exc_d    = 1'b0;
            end
          end else begin
            // Restoring step: keep the trial subtraction only if non-negative.
            if (!rem_diff[32]) begin
              rem_d = rem_diff[31:0];
              quo_d = {quo_q[30:0], 1'b1};
            end else begin
              rem_d = rem_shift[31:0];
              quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + CntW'(1);
          end
        end
`endif
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef MULTDIV_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef MULTDIV_DIV_EN
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign latched_A      = a_q;
  assign latched_B      = b_q;
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq. Inputs change and outputs are sampled on the
// falling clock edge. Window index 0 is the cycle right after the start edge,
// so a multiply or divide result strobe is expected at index 33.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] latched_A;
  logic [31:0] latched_B;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int passed = 0;
  int total  = 0;

  int          n_rdy;
  int          first;
  logic [31:0] res;
  logic        exc;

  multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .latched_A      (latched_A),
    .latched_B      (latched_B),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive a start pulse from the current falling edge; returns at index 0.
  task automatic start_op(input logic mul, input logic div, input logic [31:0] a,
                          input logic [31:0] b);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Watch 40 cycles from index 0; report strobe count, first index and result.
  task automatic watch(output int n, output int idx, output logic [31:0] r, output logic e);
    n   = 0;
    idx = -1;
    r   = 32'hDEAD_BEEF;
    e   = 1'bx;
    for (int i = 0; i < 40; i++) begin
      if (data_resultRDY) begin
        if (n == 0) begin
          idx = i;
          r   = data_result;
          e   = data_exception;
        end
        n++;
      end
      @(negedge clock);
    end
  endtask

  task automatic run_op(input string tag, input logic mul, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e);
    start_op(mul, ~mul, a, b);
    watch(n_rdy, first, res, exc);
    check({tag, "_nrdy"}, 64'(n_rdy), 64'd1);
    check({tag, "_idx"}, 64'(first), 64'd33);
    check({tag, "_res"}, {32'd0, res}, {32'd0, exp_r});
    check({tag, "_exc"}, {63'd0, exc}, {63'd0, exp_e});
  endtask

  initial begin
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("rst_res", {32'd0, data_result}, 64'd0);
    check("rst_exc", {63'd0, data_exception}, 64'd0);
    check("rst_rdy", {63'd0, data_resultRDY}, 64'd0);
    check("rst_la", {32'd0, latched_A}, 64'd0);
    check("rst_lb", {32'd0, latched_B}, 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // 7 * -3
    run_op("mul_7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    check("mul_7xm3_la", {32'd0, latched_A}, 64'd7);
    check("mul_7xm3_lb", {32'd0, latched_B}, 64'hFFFF_FFFD);
    check("hold_res", {32'd0, data_result}, 64'hFFFF_FFEB);
    check("hold_exc", {63'd0, data_exception}, 64'd0);

    run_op("mul_ovf16", 1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("mul_m1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("mul_min_x1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    run_op("mul_min_xm1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("mul_max_x2", 1'b1, 32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1);
    run_op("mul_1000", 1'b1, 32'd1000, 32'hFFFF_FC18, 32'hFFF0_BDC0, 1'b0);

    // Both starts on one edge: multiply wins.
    start_op(1'b1, 1'b1, 32'd3, 32'd4);
    watch(n_rdy, first, res, exc);
    check("prio_idx", 64'(first), 64'd33);
    check("prio_res", {32'd0, res}, 64'd12);

`ifdef MULTDIV_DIV_EN
    run_op("div_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_op("div_by0", 1'b0, 32'd7, 32'd0, 32'd0, 1'b1);
    run_op("div_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run_op("div_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("div_m100_m7", 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 1'b0);
    run_op("div_100_m7", 1'b0, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
`endif

    // Divide start, then a multiply ten cycles later.
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
`ifdef MULTDIV_DIV_EN
    check("div_abort_rdy0", {63'd0, data_resultRDY}, 64'd0);
`else
    check("nodiv_rdy", {63'd0, data_resultRDY}, 64'd1);
    check("nodiv_res", {32'd0, data_result}, 64'd0);
    check("nodiv_exc", {63'd0, data_exception}, 64'd1);
`endif
    repeat (9) @(negedge clock);
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    watch(n_rdy, first, res, exc);
    check("abort_nrdy", 64'(n_rdy), 64'd1);
    check("abort_idx", 64'(first), 64'd33);
    check("abort_res", {32'd0, res}, 64'd12);

    // Multiply aborted by another multiply.
    start_op(1'b1, 1'b0, 32'd5, 32'd6);
    repeat (10) @(negedge clock);
    run_op("mul_abort", 1'b1, 32'd9, 32'd9, 32'd81, 1'b0);

    // New start in the DONE cycle.
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    repeat (33) @(negedge clock);
    check("done_rdy", {63'd0, data_resultRDY}, 64'd1);
    check("done_res", {32'd0, data_result}, 64'd6);
    run_op("done_restart", 1'b1, 32'd4, 32'd5, 32'd20, 1'b0);

    // Reset during a multiply.
    start_op(1'b1, 1'b0, 32'd7, 32'd9);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_res", {32'd0, data_result}, 64'd0);
    check("midrst_la", {32'd0, latched_A}, 64'd0);
    check("midrst_lb", {32'd0, latched_B}, 64'd0);
    check("midrst_rdy", {63'd0, data_resultRDY}, 64'd0);
    watch(n_rdy, first, res, exc);
    check("midrst_nrdy", 64'(n_rdy), 64'd0);

    // Reset wins over a start on the same edge.
    run_op("pre_rst", 1'b1, 32'd11, 32'd2, 32'd22, 1'b0);
    reset = 1'b1;
    start_op(1'b1, 1'b0, 32'd5, 32'd5);
    reset = 1'b0;
    check("rstwin_la", {32'd0, latched_A}, 64'd0);
    check("rstwin_res", {32'd0, data_result}, 64'd0);
    watch(n_rdy, first, res, exc);
    check("rstwin_nrdy", 64'(n_rdy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
